// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps one memory request outstanding.
// Holds one fetched word for IF/ID and discards responses made stale by a redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE, READY, BUSY, DRAIN} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] addr;
  } fbuf_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] req_addr_q, req_addr_n;
  fbuf_t       buf_q, buf_n;

  logic        room, consume, issue, load;
  logic [31:0] load_addr;

  assign room    = ~buf_q.valid | ~stall_i;
  assign consume = buf_q.valid & ~stall_i;
  assign issue   = (state_q == READY) & start_i & room & ~branch_taken_i;

  assign mem_req_o  = issue | (state_q == BUSY) | (state_q == DRAIN);
  assign mem_addr_o = (state_q == READY) ? pc_q : req_addr_q;

  assign inst_o  = buf_q.valid ? buf_q.inst : NOP_WORD;
  assign pc_o    = buf_q.addr + 32'd4;
  assign valid_o = buf_q.valid;

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    req_addr_n = req_addr_q;
    buf_n      = buf_q;
    load       = 1'b0;
    load_addr  = pc_q;

    case (state_q)
      IDLE: if (start_i) state_n = READY;
      READY: begin
        if (issue) begin
          if (mem_ack_i) begin
            load      = 1'b1;
            load_addr = pc_q;
          end else begin
            req_addr_n = pc_q;
            state_n    = BUSY;
          end
        end
      end
      BUSY: begin
        if (branch_taken_i) begin
          state_n = mem_ack_i ? READY : DRAIN;
        end else if (mem_ack_i) begin
          load      = 1'b1;
          load_addr = req_addr_q;
          state_n   = READY;
        end
      end
      DRAIN: if (mem_ack_i) state_n = READY;
      default: state_n = IDLE;
    endcase

    if (load) pc_n = pc_q + 32'd4;

    // Redirect wins over everything; buf_addr follows the new PC so pc_o tracks it.
    if (branch_taken_i) begin
      pc_n        = branch_target_i;
      buf_n.valid = 1'b0;
      buf_n.addr  = branch_target_i;
    end else if (load) begin
      buf_n.valid = 1'b1;
      buf_n.inst  = mem_data_i;
      buf_n.addr  = load_addr;
    end else if (consume || !buf_q.valid) begin
      buf_n.valid = 1'b0;
      buf_n.addr  = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= '{valid: 1'b0, inst: NOP_WORD, addr: RESET_PC};
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      req_addr_q <= req_addr_n;
      buf_q      <= buf_n;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the instruction/PC pair latched by the IF/ID pipeline register. Owns the program counter, issues single-outstanding requests to a variable-latency instruction memory (req/ack), holds one fetched instruction while IF/ID is stalled, and handles branch redirects, including discarding in-flight responses. When no instruction is ready it presents a NOP (all-zero word), so IF/ID fills with bubbles.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_WORD, 32'h0000_0000, word presented on inst_o when no valid instruction is held

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  pipeline enable; 0 = no new requests issued
stall_i  input  1  IF/ID stall (same signal fed to IF/ID); 1 = held instruction not consumed this cycle
branch_taken_i  input  1  single-cycle redirect pulse from ID
branch_target_i  input  32  redirect target address
mem_req_o  output  1  instruction memory request
mem_addr_o  output  32  request address, word aligned
mem_ack_i  input  1  memory response valid; may be asserted in the same cycle as mem_req_o
mem_data_i  input  32  instruction word, valid with mem_ack_i
inst_o  output  32  instruction to IF/ID inst_i
pc_o  output  32  fetch address + 4, to IF/ID PC_i
valid_o  output  1  held instruction is real (not a bubble)

Behaviour:
- One clock (clk_i); reset is synchronous, active-high (rst_i). All registers update only on the posedge.
- Registers: pc_q, req_addr_q, buf_valid, buf_inst, buf_addr, state in {IDLE, READY, BUSY, DRAIN}.
- Reset: pc_q=RESET_PC, buf_valid=0, state=IDLE. Outputs after reset: mem_req_o=0, valid_o=0, inst_o=NOP_WORD, pc_o=RESET_PC+4, mem_addr_o=RESET_PC.
- Output mapping: inst_o = buf_valid ? buf_inst : NOP_WORD; pc_o = buf_addr+4 (buf_addr tracks pc_q while empty); valid_o = buf_valid.
- room = ~buf_valid | ~stall_i. The held instruction is consumed at a posedge where buf_valid & ~stall_i.
- issue = state==READY & start_i & room & ~branch_taken_i.
- mem_req_o = issue | state==BUSY | state==DRAIN. mem_addr_o = pc_q in READY, req_addr_q otherwise. Once asserted, req and addr are held stable until ack; a request is never withdrawn.
- Only one request may be outstanding. Because issue requires room, the buffer is always empty or being consumed when an ack arrives, so it never overflows.
- IDLE: go to READY when start_i=1.
- READY: on issue with ack in the same cycle, load the buffer and set pc_q+=4; stay READY. This gives a throughput of 1 instr/cycle with zero-wait memory. On issue without ack, set req_addr_q=pc_q and go to BUSY.
- BUSY: on ack, load the buffer (buf_inst=mem_data_i, buf_addr=req_addr_q, buf_valid=1), set pc_q+=4, go to READY.
- DRAIN: keep the request asserted at req_addr_q. On ack, discard the data, leave the buffer untouched (empty), go to READY.
- Redirect (branch_taken_i=1) has priority over stall, ack and consume:
  - Set pc_q=branch_target_i and buf_valid=0.
  - In BUSY without ack: go to DRAIN.
  - In BUSY with ack, or in DRAIN with ack: discard the data, go to READY.
  - In DRAIN without ack: stay in DRAIN.
  - In READY: no issue that cycle.
- Second redirect during DRAIN: pc_q takes the newest target. The single pending ack is still discarded.
- Buffer update with consume and no ack: buf_valid=0, buf_addr=pc_q.
- start_i=0: no new issue. An outstanding BUSY/DRAIN completes normally. The held buffer stays presented.
- pc_q arithmetic is modulo 2^32 and wraps 32'hFFFF_FFFC -> 0.
- Reset mid-transaction returns to IDLE with the request dropped. The instruction memory shares rst_i, so no stale ack follows.

Test Plan:
- Zero-wait memory (ack tied to req), start_i=1, no stall: after reset, inst_o streams mem[0],mem[4],mem[8] on consecutive cycles with pc_o=4,8,12; valid_o=1 from the cycle after the first ack.
- 3-cycle ack latency: mem_req_o held 3 cycles at addr 0 -> valid_o pulses per instruction, inst_o=NOP_WORD between, no second request while BUSY.
- stall_i=1 for 4 cycles with buffer full: no new mem_req_o, inst_o/pc_o constant. Stall released -> next request issued the same cycle, no instruction lost or duplicated.
- Redirect to 0x100 while BUSY at addr 0x8 with ack 2 cycles later: request for 0x8 held to ack, data discarded, next request addr=0x100, inst_o never shows mem[0x8].
- Redirect in the same cycle as ack, and redirect with stall_i=1: buffer cleared, next fetch from target, valid_o=0 for the following cycle.
- rst_i asserted while BUSY: next cycle mem_req_o=0, valid_o=0, pc_o=RESET_PC+4, state IDLE. pc_q at 0xFFFFFFFC fetch wraps next addr to 0.
